// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side streamer for dual_clock_fifo with read-latency absorption and 4-entry skid buffer.
// Optional FIFO_STREAM_READER_STATS_EN adds o_word_cnt / o_stall_cnt statistics outputs.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_srst_n,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_re,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic [2:0]            o_level
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]           o_word_cnt,
  output logic [31:0]           o_stall_cnt
`endif
);

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("fifo_stream_reader: RD_LATENCY must be 1 or 2");
  end
  if (BUF_DEPTH != 4) begin : g_bad_depth
    $error("fifo_stream_reader: BUF_DEPTH must be 4");
  end

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0]   mem_q [4];
  logic [DATA_WIDTH-1:0]   mem_d [4];
  logic [1:0]              rd_q, rd_d, wr_q, wr_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              inflight;
  logic                    run, push, pop, clr;

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) state_q <= RUN;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = (state_q == RUN) ? (i_flush ? FLUSH : RUN) : ((pipe_q == '0) ? RUN : FLUSH);
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + 3'(pipe_q[i]);
    run = (state_q == RUN);
    // Gating on i_flush keeps the request cycle from launching a read that would only be discarded.
    o_fifo_re = i_srst_n & run & ~i_flush & ~i_fifo_empty &
                (({1'b0, cnt_q} + {1'b0, inflight}) < 4'(BUF_DEPTH));
    o_valid = (cnt_q != '0);
    o_data = mem_q[rd_q];
    o_busy = ~run;
    o_level = cnt_q;
    push = run & pipe_q[RD_LATENCY-1];
    pop = o_valid & i_ready;
    pipe_d = RD_LATENCY'({pipe_q, o_fifo_re});
    mem_d = mem_q;
    if (push) mem_d[wr_q] = i_fifo_rdata;
    clr = ~run | i_flush;
    cnt_d = clr ? '0 : cnt_q + 3'(push) - 3'(pop);
    rd_d = clr ? '0 : rd_q + 2'(pop);
    wr_d = clr ? '0 : wr_q + 2'(push);
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      pipe_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assert property (@(posedge i_clk) disable iff (!i_srst_n) !(push && cnt_q == 3'd4 && !pop));

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q + 32'(pop);
    stall_cnt_d = stall_cnt_q + 32'(o_valid & ~i_ready);
  end

  always_ff @(posedge i_clk) begin
    if (!i_srst_n) begin
      word_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_word_cnt = word_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench for fifo_stream_reader at RD_LATENCY 1 (u_a) and 2 (u_b).
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst_n;
  logic a_empty, a_re, a_valid, a_ready, a_flush, a_busy;
  logic [7:0] a_rdata, a_data;
  logic [2:0] a_level;
  logic b_empty, b_re, b_valid, b_ready, b_flush, b_busy;
  logic [7:0] b_rdata, b_data;
  logic [2:0] b_level;
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] a_word_cnt, a_stall_cnt, b_word_cnt, b_stall_cnt;
`endif

  fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(1)) u_a (
    .i_clk(clk), .i_srst_n(srst_n), .i_fifo_empty(a_empty), .o_fifo_re(a_re),
    .i_fifo_rdata(a_rdata), .o_valid(a_valid), .o_data(a_data), .i_ready(a_ready),
    .i_flush(a_flush), .o_busy(a_busy), .o_level(a_level)
`ifdef FIFO_STREAM_READER_STATS_EN
    , .o_word_cnt(a_word_cnt), .o_stall_cnt(a_stall_cnt)
`endif
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .RD_LATENCY(2)) u_b (
    .i_clk(clk), .i_srst_n(srst_n), .i_fifo_empty(b_empty), .o_fifo_re(b_re),
    .i_fifo_rdata(b_rdata), .o_valid(b_valid), .o_data(b_data), .i_ready(b_ready),
    .i_flush(b_flush), .o_busy(b_busy), .o_level(b_level)
`ifdef FIFO_STREAM_READER_STATS_EN
    , .o_word_cnt(b_word_cnt), .o_stall_cnt(b_stall_cnt)
`endif
  );

  // FIFO models: a returns data one cycle after re, b two cycles after re.
  logic [7:0] fa_mem [64];
  logic [7:0] fb_mem [64];
  int fa_wr = 0, fa_rd = 0, fb_wr = 0, fb_rd = 0;
  logic a_pipe = 1'b0;
  logic [1:0] b_pipe = 2'b00;
  logic [7:0] b_s1;
  assign a_empty = (fa_rd == fa_wr);
  assign b_empty = (fb_rd == fb_wr);

  always @(posedge clk) begin
    if (a_re) begin
      a_rdata <= fa_mem[fa_rd % 64];
      fa_rd <= fa_rd + 1;
    end
    a_pipe <= a_re;
  end

  always @(posedge clk) begin
    if (b_re) begin
      b_s1 <= fb_mem[fb_rd % 64];
      fb_rd <= fb_rd + 1;
    end
    b_rdata <= b_s1;
    b_pipe <= {b_pipe[0], b_re};
  end

  int checks = 0, errors = 0;
  int cyc_n = 0, bad_empty = 0, bad_cap = 0;
  logic s_a_re, s_a_valid, s_b_re, s_b_valid, s_b_busy, s_b_pop;
  logic [7:0] s_a_data, s_b_data;
  logic [2:0] s_a_level, s_b_level;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    #1;
    s_a_re = a_re; s_a_valid = a_valid; s_a_data = a_data; s_a_level = a_level;
    s_b_re = b_re; s_b_valid = b_valid; s_b_data = b_data; s_b_level = b_level;
    s_b_busy = b_busy; s_b_pop = b_valid & b_ready;
    if ((a_re && a_empty) || (b_re && b_empty)) bad_empty++;
    if (a_re && (int'(a_level) + int'(a_pipe)) >= 4) bad_cap++;
    if (b_re && (int'(b_level) + int'(b_pipe[0]) + int'(b_pipe[1])) >= 4) bad_cap++;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic load_b(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      fb_mem[fb_wr % 64] = base + 8'(i);
      fb_wr++;
    end
  endtask

  task automatic drain_b(input int n, input logic [7:0] base, input string tag, output int first, output int last);
    int got;
    got = 0; first = 0; last = 0;
    for (int k = 0; k < n * 4 + 20 && got < n; k++) begin
      cyc();
      if (s_b_pop) begin
        chk(tag, 32'(s_b_data), 32'(base + 8'(got)));
        if (got == 0) first = cyc_n;
        last = cyc_n;
        got++;
      end
    end
    chk({tag, "_cnt"}, 32'(got), 32'(n));
  endtask

  initial begin
    logic [5:0] re_seq, v_seq;
    logic [7:0] a_d [6];
    int re_cnt, unstable, f, l, got;
    srst_n = 1'b0; a_ready = 1'b0; b_ready = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_re", 32'(s_b_re), 0);
    chk("rst_valid", 32'(s_b_valid), 0);
    chk("rst_data", 32'(s_b_data), 0);
    chk("rst_busy", 32'(s_b_busy), 0);
    chk("rst_level", 32'(s_b_level), 0);
    srst_n = 1'b1;
    cyc();
    // latency-1 burst of three words
    fa_mem[0] = 8'h11; fa_mem[1] = 8'h22; fa_mem[2] = 8'h33; fa_wr = 3;
    a_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      re_seq[i] = s_a_re; v_seq[i] = s_a_valid; a_d[i] = s_a_data;
    end
    chk("t1_re_seq", 32'(re_seq), 32'b000111);
    chk("t1_valid_seq", 32'(v_seq), 32'b011100);
    chk("t1_d0", 32'(a_d[2]), 32'h11);
    chk("t1_d1", 32'(a_d[3]), 32'h22);
    chk("t1_d2", 32'(a_d[4]), 32'h33);
    chk("t1_level", 32'(s_a_level), 0);
    // latency-2 fill under backpressure, then drain
    load_b(16, 8'hA0);
    re_cnt = 0; unstable = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      re_cnt += int'(s_b_re);
      if (s_b_valid && s_b_data != 8'hA0) unstable++;
    end
    chk("t2_re_pulses", 32'(re_cnt), 4);
    chk("t2_level", 32'(s_b_level), 4);
    chk("t2_head", 32'(s_b_data), 32'hA0);
    chk("t2_stable", 32'(unstable), 0);
    b_ready = 1'b1;
    drain_b(16, 8'hA0, "t2_word", f, l);
    chk("t2_span", 32'(l - f), 15);
    // alternating ready over 32 words
    load_b(32, 8'h40);
    got = 0;
    for (int k = 0; k < 200 && got < 32; k++) begin
      b_ready = (k % 2 == 0);
      cyc();
      if (s_b_pop) begin
        chk("t3_word", 32'(s_b_data), 32'(8'h40 + 8'(got)));
        got++;
      end
    end
    chk("t3_cnt", 32'(got), 32);
    b_ready = 1'b1;
    repeat (4) cyc();
    // flush with two words buffered and two in flight
    b_ready = 1'b0;
    load_b(8, 8'hC0);
    repeat (4) cyc();
    b_flush = 1'b1;
    cyc();
    chk("t4_pre_level", 32'(s_b_level), 2);
    b_flush = 1'b0;
    cyc();
    chk("t4_valid", 32'(s_b_valid), 0);
    chk("t4_busy1", 32'(s_b_busy), 1);
    chk("t4_re1", 32'(s_b_re), 0);
    chk("t4_level", 32'(s_b_level), 0);
    cyc();
    chk("t4_busy2", 32'(s_b_busy), 1);
    chk("t4_re2", 32'(s_b_re), 0);
    cyc();
    chk("t4_busy3", 32'(s_b_busy), 0);
    b_ready = 1'b1;
    drain_b(4, 8'hC4, "t4_word", f, l);
    // reset with two reads in flight
    repeat (2) cyc();
    load_b(8, 8'hD0);
    repeat (2) cyc();
    srst_n = 1'b0;
    cyc(); cyc();
    chk("t5_re", 32'(s_b_re), 0);
    chk("t5_valid", 32'(s_b_valid), 0);
    chk("t5_data", 32'(s_b_data), 0);
    chk("t5_busy", 32'(s_b_busy), 0);
    chk("t5_level", 32'(s_b_level), 0);
    srst_n = 1'b1;
    drain_b(6, 8'hD2, "t5_word", f, l);
`ifdef FIFO_STREAM_READER_STATS_EN
    srst_n = 1'b0;
    cyc();
    srst_n = 1'b1;
    b_ready = 1'b0;
    load_b(10, 8'hE0);
    repeat (8) cyc();
    b_ready = 1'b1;
    drain_b(10, 8'hE0, "t6_word", f, l);
    repeat (2) cyc();
    chk("t6_words", b_word_cnt, 10);
    chk("t6_stalls", b_stall_cnt, 5);
    b_flush = 1'b1;
    cyc();
    b_flush = 1'b0;
    repeat (2) cyc();
    chk("t6_flush_words", b_word_cnt, 10);
    chk("t6_flush_stalls", b_stall_cnt, 5);
    srst_n = 1'b0;
    cyc(); cyc();
    chk("t6_rst_words", b_word_cnt, 0);
    chk("t6_rst_stalls", b_stall_cnt, 0);
    srst_n = 1'b1;
    cyc();
`endif
    chk("no_re_when_empty", 32'(bad_empty), 0);
    chk("no_re_at_capacity", 32'(bad_cap), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
